// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused once per clock, LSB
// first, with a valid/ready handshake on both the operand and result sides.

// Single-bit full adder, the only arithmetic in the block.
module sa_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             accept, last, retire;

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign accept      = start_valid & start_ready;
   // Final bit of the operation: the cell output this edge is the MSB.
   assign last        = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign retire      = done_valid & done_ready;

   sa_fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; there is no DONE->accept bypass, IDLE must be visited.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last)   state_nxt = DONE;
         DONE:    if (retire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, per-bit shift/add, result publish and retire.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         sum        <= '0;
         cout       <= 1'b0;
         done_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh <= {fa_s, res_sh[WIDTH-1:1]};
               carry  <= fa_c;
               if (last) begin
                  // Publish the completed word including this edge's bit.
                  sum        <= {fa_s, res_sh[WIDTH-1:1]};
                  cout       <= fa_c;
                  done_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (retire) done_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
